// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage pipeline (IF/ID, X, WB).
// Resolves the hazards that forwarding cannot resolve: load-use, cache stalls,
// branch redirect and CSR/fence serialization. Also keeps the performance counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             br_taken_X,
  input  logic             is_load_X,
  input  logic             rf_wen_X,
  input  logic [4:0]       rd_X,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs1_ID,
  input  logic             uses_rs2_ID,
  input  logic             serial_ID,
  input  logic             valid_WB,
  input  logic             cnt_clear,
  output logic             freeze,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             bubble_X,
  output logic             kill_ID,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, FREEZE, FLUSH, DRAIN} state_t;

  localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES);
  localparam logic [1:0]       DRAIN_INIT = 2'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_reg, state_next;
  state_t     ret_state_reg, ret_state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [1:0] ret_cnt_reg, ret_cnt_next;

  state_t     eff_state;
  logic [1:0] eff_cnt;
  logic       mem_stall;
  logic       lu_haz;
  logic       hold;

  assign mem_stall = icache_stall | dcache_stall;
  assign lu_haz    = is_load_X & rf_wen_X & (rd_X != 5'd0) &
                     ((uses_rs1_ID & (rd_X == rs1_ID)) | (uses_rs2_ID & (rd_X == rs2_ID)));

  // Once a freeze lifts, the cycle is evaluated as the state that was interrupted.
  assign eff_state = (state_reg == FREEZE) ? ret_state_reg : state_reg;
  assign eff_cnt   = (state_reg == FREEZE) ? ret_cnt_reg   : cnt_reg;

  assign stall_IF = hold;
  assign stall_ID = hold;
  assign bubble_X = hold;

  // Next-state and same-cycle control outputs.
  always_comb begin
    freeze         = 1'b0;
    hold           = 1'b0;
    kill_ID        = 1'b0;
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ret_state_next = ret_state_reg;
    ret_cnt_next   = ret_cnt_reg;
    if (rst) begin
      state_next = RUN;
    end else if (mem_stall) begin
      freeze     = 1'b1;
      state_next = FREEZE;
      // A freeze extending an existing freeze must keep the original resume point.
      if (state_reg != FREEZE) begin
        ret_state_next = state_reg;
        ret_cnt_next   = cnt_reg;
      end
    end else begin
      state_next = eff_state;
      cnt_next   = eff_cnt;
      case (eff_state)
        RUN: begin
          // The redirect wins: the ID instruction is on the wrong path anyway.
          if (br_taken_X) begin
            kill_ID    = 1'b1;
            cnt_next   = FLUSH_INIT;
            state_next = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
          end else if (lu_haz) begin
            hold = 1'b1;
          end else if (serial_ID) begin
            hold       = 1'b1;
            cnt_next   = DRAIN_INIT;
            state_next = DRAIN;
          end
        end
        FLUSH: begin
          kill_ID = 1'b1;
          if (eff_cnt <= 2'd1) begin
            cnt_next   = 2'd0;
            state_next = RUN;
          end else begin
            cnt_next = eff_cnt - 2'd1;
          end
        end
        DRAIN: begin
          // At zero the serializing instruction is released; serial_ID is not looked at here.
          if (eff_cnt == 2'd0) begin
            state_next = RUN;
          end else begin
            hold     = 1'b1;
            cnt_next = eff_cnt - 2'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      cnt_reg       <= 2'd0;
      ret_state_reg <= RUN;
      ret_cnt_reg   <= 2'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ret_state_reg <= ret_state_next;
      ret_cnt_reg   <= ret_cnt_next;
    end
  end

  // Performance counters, wrapping; clear overrides any increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (valid_WB && !freeze)
        instret_cnt <= instret_cnt + CNT_ONE;
      if (freeze || stall_ID || kill_ID)
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 3-stage RISC-V pipeline (IF/ID, X, WB).
- Consumes hazard and memory-status signals and drives the pipeline-register enables, the bubble insertion into X and the kill of the ID instruction.
- Complements the forwarding unit: it handles every hazard that forwarding cannot resolve. These are load-use, cache stalls, branch redirect, and CSR/fence serialization.
- Also maintains the cycle, instret and stall performance counters read by the CSR path.

Parameters:
- FLUSH_CYCLES, 1: extra cycles after a redirect during which the fetched instruction is killed (sync I-mem latency).
- DRAIN_CYCLES, 2: cycles the pipeline is drained before a serializing instruction in ID may issue.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- icache_stall  in  1  I-cache not ready (level)
- dcache_stall  in  1  D-cache not ready (level)
- br_taken_X  in  1  branch/jump in X redirects the PC
- is_load_X  in  1  X instruction is a load
- rf_wen_X  in  1  X instruction writes the RF
- rd_X  in  5  X destination register
- rs1_ID  in  5  ID source register 1
- rs2_ID  in  5  ID source register 2
- uses_rs1_ID  in  1  ID instruction reads rs1
- uses_rs2_ID  in  1  ID instruction reads rs2
- serial_ID  in  1  ID holds a CSR or fence instruction
- valid_WB  in  1  valid instruction retiring in WB
- cnt_clear  in  1  synchronously zero all counters
- freeze  out  1  hold every pipeline register
- stall_IF  out  1  hold the PC
- stall_ID  out  1  hold the IF/ID register
- bubble_X  out  1  load a NOP into X
- kill_ID  out  1  replace the ID instruction with a NOP
- cycle_cnt  out  CNT_W  cycle counter
- instret_cnt  out  CNT_W  retired-instruction counter
- stall_cnt  out  CNT_W  lost-cycle counter

Behaviour:
- FSM states: RUN, FREEZE, FLUSH, DRAIN. A 2-bit down-counter cnt serves FLUSH and DRAIN. A ret_state register records the state to resume after FREEZE.
- All control outputs are combinational from the state and the current inputs, so a stall takes effect in the same cycle it is detected.
- Define mem_stall = icache_stall | dcache_stall.
- Define lu_haz = is_load_X & rf_wen_X & (rd_X != 0) & ((uses_rs1_ID & rd_X == rs1_ID) | (uses_rs2_ID & rd_X == rs2_ID)).
- Reset:
  - State is RUN; cnt, ret_state and all counters are 0.
  - While rst is high, all control outputs are 0.
- mem_stall in any state:
  - Go to FREEZE and save the current state and cnt into ret_state.
  - freeze=1 in that same cycle; all other control outputs are 0.
- FREEZE:
  - freeze=1 while mem_stall holds.
  - On the first cycle with mem_stall=0: freeze=0, and evaluate this cycle exactly as the saved state would.
- RUN, priority high to low:
  - mem_stall: handled as above.
  - br_taken_X: kill_ID=1; go to FLUSH with cnt=FLUSH_CYCLES. This takes precedence over lu_haz and serial_ID, because the ID instruction is dead.
  - lu_haz: stall_IF=stall_ID=bubble_X=1 for this single cycle; stay in RUN. The load is in WB next cycle and is forwarded there.
  - serial_ID: stall_IF=stall_ID=bubble_X=1; go to DRAIN with cnt=DRAIN_CYCLES-1.
- FLUSH:
  - kill_ID=1 every cycle; decrement cnt; go to RUN when cnt reaches 0.
  - A new br_taken_X cannot occur here, since X holds bubbles.
- DRAIN:
  - stall_IF=stall_ID=bubble_X=1; decrement cnt.
  - At cnt==0, release ID for one cycle with no stall outputs, then return to RUN.
  - serial_ID stays asserted while held, so the return to RUN must not re-trigger DRAIN on the released instruction. The DRAIN-exit cycle masks serial_ID.
- Counters, all wrapping modulo 2^CNT_W:
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments when valid_WB & !freeze.
  - stall_cnt increments when freeze | stall_ID | kill_ID.
  - cnt_clear zeros all three in the next cycle and overrides any increment.
- Reset asserted mid-FREEZE, FLUSH or DRAIN returns to RUN with no residual kill or stall.

Test Plan:
- Load-use: lw x5 in X, add with rs1=x5 in ID -> exactly 1 cycle of stall_IF=stall_ID=bubble_X=1, then 0. The same case with rd_X=x0 gives no stall.
- Redirect: br_taken_X=1 for 1 cycle with FLUSH_CYCLES=1 -> kill_ID=1 for 2 consecutive cycles. A simultaneous lu_haz is ignored.
- CSR serialize: serial_ID held high -> 2 stall cycles, 1 release cycle, then RUN. stall_cnt advances by 2.
- D-cache miss inside FLUSH: dcache_stall high for 5 cycles after the redirect cycle -> freeze=1 for 5 cycles, then the remaining kill_ID cycle is issued. Total kill_ID count is 2.
- Counters: 100 cycles with valid_WB=1 and no stalls -> cycle_cnt=100, instret_cnt=100. Preload cycle_cnt to 0xFFFFFFFF and step once -> 0. cnt_clear -> all counters 0.
- Reset mid-DRAIN: rst pulsed for 1 cycle -> all outputs 0 and the state is RUN on the following cycle.
